interp_dac_out: RTL
===================

Name: interp_dac_out

Overview:
- Downstream stage of the FIR interpolation controller.
- Captures each interpolated output sample when the controller pulses sample_rdy and buffers it in a small FIFO.
- Releases samples at a fixed output-sample rate and serialises each one as a 24-bit SPI frame to the DAC.
- Reports FIFO level and sticky overflow/underrun flags so rate mismatches between the filter and the DAC are visible.

Parameters:
- DW, 16: sample width in bits (two's-complement filter output).
- DEPTH, 8: FIFO entries; must be a power of 2.
- AW, 3: FIFO address width, log2(DEPTH).
- SAMPLE_DIV, 256: CLOCK cycles per output sample. Must be at least FRAME_CYCLES+2; a simulation assertion enforces this.
- SCLK_HALF, 2: CLOCK cycles per SCLK half-period, at least 1.
- DAC_CMD, 8'h30: command byte prefixed to every frame.

Ports:
- CLOCK  in  1  system clock.
- RESET  in  1  asynchronous, active-low reset.
- sample_rdy  in  1  one-cycle strobe from the controller; sample_in is valid in that cycle.
- sample_in  in  DW  interpolated sample.
- clr_flags  in  1  synchronous clear of the sticky flags.
- dac_cs_n  out  1  DAC chip select, active low.
- dac_sclk  out  1  SPI clock, idle low.
- dac_mosi  out  1  SPI data, MSB first.
- frame_done  out  1  one-cycle pulse when a frame completes.
- fifo_level  out  AW+1  current occupancy, 0..DEPTH.
- buf_afull  out  1  asserted when fifo_level >= DEPTH-2.
- overflow  out  1  sticky: a sample was dropped.
- underrun  out  1  sticky: a tick found the FIFO empty.

Behaviour:
- Reset (RESET=0, asynchronous):
  - dac_cs_n=1, dac_sclk=0, dac_mosi=0, frame_done=0.
  - FIFO emptied (fifo_level=0), overflow=0, underrun=0.
  - last_sample=0, tick counter=0, FSM=IDLE.
  - Reset mid-frame aborts the frame immediately; no partial completion.
- Write side:
  - On sample_rdy, write sample_in if fifo_level<DEPTH, or if a pop occurs in the same cycle.
  - Otherwise drop the sample and set overflow.
  - A simultaneous write and pop leaves fifo_level unchanged.
- Tick counter:
  - Free-runs 0..SAMPLE_DIV-1 and wraps to 0.
  - tick is asserted when count=SAMPLE_DIV-1. The first tick occurs SAMPLE_DIV cycles after reset release.
- On tick with FSM=IDLE:
  - If FIFO non-empty: pop the head into last_sample and the shift register.
  - If FIFO empty: reuse last_sample and set underrun. This holds DAC output and keeps the frame rate constant.
  - In both cases, go to LOAD.
- A tick while the FSM is not IDLE is a parameter violation; the tick is ignored and the assertion fires.
- Frame: shift register = {DAC_CMD, sample}, FRAME_BITS=24.
- FSM states:
  - IDLE: dac_cs_n=1, dac_sclk=0. Leaves only on tick.
  - LOAD: 1 cycle. dac_cs_n=0, dac_mosi=bit 23, bit counter=0, half-period timer=0. Next state SHIFT.
  - SHIFT: dac_sclk toggles every SCLK_HALF cycles.
    - The DAC samples MOSI on the rising edge.
    - The shift register advances on each falling edge, and dac_mosi takes the next bit.
    - After the 24th falling edge, go to CS_HOLD with dac_sclk=0.
  - CS_HOLD: dac_cs_n=1 for SCLK_HALF cycles. frame_done pulses on the last cycle. Next state IDLE.
- FRAME_CYCLES = 1 + 48*SCLK_HALF + SCLK_HALF (99 with defaults).
- Width rules: sample_in is passed unmodified (no truncation or rounding). fifo_level is AW+1 bits so it can represent DEPTH.
- clr_flags clears overflow and underrun. If a set event occurs in the same cycle, set wins.
- dac_sclk, dac_cs_n and dac_mosi are driven directly from flops (glitch-free).

Decomposition:
- Package interp_out_pkg:
  - FRAME_BITS=24.
  - Serialiser state encoding: IDLE, LOAD, SHIFT, CS_HOLD.
  - Localparam function computing FRAME_CYCLES.
- Sub-module sample_fifo:
  - Synchronous DEPTH x DW register FIFO with wr_en, rd_en, level, full and empty.
  - Same CLOCK/RESET convention.
- The top level holds the tick counter, the serialiser FSM and the flags.

Test Plan:
- Basic frame: after reset, one sample_rdy with sample_in=16'hA5C3 before the first tick.
  - dac_cs_n falls at cycle 256 after reset.
  - 24 rising SCLK edges carry 24'h30A5C3, MSB first.
  - frame_done pulses 99 cycles after LOAD; fifo_level returns to 0.
- Underrun hold: send one sample 16'h1234, then none.
  - The second frame repeats 24'h301234 and underrun=1.
  - clr_flags clears underrun.
- Overflow: 9 sample_rdy strobes, values 1..9, with no tick in between.
  - fifo_level=8, buf_afull=1, overflow=1.
  - Frames then output 1..8 in order; 9 is dropped.
- Simultaneous write and pop: sample_rdy asserted in the tick cycle with FIFO full (level 8).
  - Write accepted, level stays 8, overflow stays 0.
- Reset mid-frame: assert RESET=0 at bit 10 of a frame.
  - Same cycle: dac_cs_n=1, dac_sclk=0, dac_mosi=0.
  - After release: fifo_level=0, flags 0, first tick at cycle 256.
- Flag race: clr_flags coincides with an overflow drop -> overflow stays 1.

Source files
------------

// File: rtl/interp_out_pkg.sv
// rtl/interp_out_pkg.sv - shared constants and types for the DAC output stage
//
// Purpose: frame geometry, serialiser state encoding and frame-length helper
// used by interp_dac_out.
// Ports: none (package).
package interp_out_pkg;

  localparam int FRAME_BITS = 24;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_CS_HOLD
  } ser_state_e;

  // One LOAD cycle, 2*FRAME_BITS SCLK half-periods, then one half-period of CS hold.
  function automatic int frame_cycles(input int sclk_half);
    return 1 + 2 * FRAME_BITS * sclk_half + sclk_half;
  endfunction

endpackage

// File: rtl/interp_dac_out_if.sv
// rtl/interp_dac_out_if.sv - sample input, SPI output and status bundle
//
// Purpose: groups the controller-facing strobe/data, the DAC SPI pins and the
// status outputs of interp_dac_out.
// Ports (signals):
//   sample_rdy, sample_in, clr_flags       : controller -> output stage
//   dac_cs_n, dac_sclk, dac_mosi           : SPI to DAC
//   frame_done, fifo_level, buf_afull,
//   overflow, underrun                     : status
// Modports: master (controller side), slave (output stage).
interface interp_dac_out_if #(
  parameter int DW = 16,
  parameter int AW = 3
);

  logic          sample_rdy;
  logic [DW-1:0] sample_in;
  logic          clr_flags;
  logic          dac_cs_n;
  logic          dac_sclk;
  logic          dac_mosi;
  logic          frame_done;
  logic [AW:0]   fifo_level;
  logic          buf_afull;
  logic          overflow;
  logic          underrun;

  modport master (
    output sample_rdy, sample_in, clr_flags,
    input  dac_cs_n, dac_sclk, dac_mosi, frame_done,
    input  fifo_level, buf_afull, overflow, underrun
  );

  modport slave (
    input  sample_rdy, sample_in, clr_flags,
    output dac_cs_n, dac_sclk, dac_mosi, frame_done,
    output fifo_level, buf_afull, overflow, underrun
  );

endinterface

// File: rtl/sample_fifo.sv
// rtl/sample_fifo.sv - DEPTH x DW register FIFO with occupancy count
//
// Purpose: buffers filter samples between capture and the output tick.
// Ports:
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   wr_en_i, wr_data_i : write strobe and data (caller guarantees room)
//   rd_en_i, rd_data_o : pop strobe and head data (head valid when !empty_o)
//   level_o, full_o, empty_o : occupancy 0..DEPTH and derived flags
module sample_fifo #(
  parameter int DW    = 16,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          wr_en_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          rd_en_i,
  output logic [DW-1:0] rd_data_o,
  output logic [AW:0]   level_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   level_q;

  // Storage needs no reset; only pointers and level define contents.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (wr_en_i) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (rd_en_i) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({wr_en_i, rd_en_i})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign level_o   = level_q;
  assign full_o    = (level_q == FULL_LVL);
  assign empty_o   = (level_q == '0);

endmodule

// File: rtl/interp_dac_out.sv
// rtl/interp_dac_out.sv - sample buffer, rate tick and SPI serialiser to the DAC
//
// Purpose: captures interpolated samples on sample_rdy, releases one per
// SAMPLE_DIV cycles and shifts {DAC_CMD, sample} out as a 24-bit SPI frame.
// Ports:
//   CLOCK : system clock
//   RESET : asynchronous active-low reset
//   bus   : interp_dac_out_if.slave (sample input, SPI pins, status)
module interp_dac_out
  import interp_out_pkg::*;
#(
  parameter int         DW         = 16,
  parameter int         DEPTH      = 8,
  parameter int         AW         = 3,
  parameter int         SAMPLE_DIV = 256,
  parameter int         SCLK_HALF  = 2,
  parameter logic [7:0] DAC_CMD    = 8'h30
) (
  input logic              CLOCK,
  input logic              RESET,
  interp_dac_out_if.slave  bus
);

  localparam int FRAME_CYCLES = frame_cycles(SCLK_HALF);
  localparam int CW  = $clog2(SAMPLE_DIV);
  localparam int HW  = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
  localparam int BCW = $clog2(FRAME_BITS);

  localparam logic [CW-1:0]  TICK_LAST = CW'(SAMPLE_DIV - 1);
  localparam logic [HW-1:0]  HALF_LAST = HW'(SCLK_HALF - 1);
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(FRAME_BITS - 1);
  localparam logic [AW:0]    AFULL_LVL = (AW + 1)'(DEPTH - 2);

  // Rate tick
  logic [CW-1:0] tick_cnt_q;
  logic          tick;

  // Serialiser
  ser_state_e            state_q, state_d;
  logic [FRAME_BITS-1:0] sr_q, sr_d;
  logic [FRAME_BITS-1:0] frame;
  logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [HW-1:0]         half_q, half_d;
  logic                  cs_n_q, cs_n_d;
  logic                  sclk_q, sclk_d;
  logic                  mosi_q, mosi_d;
  logic                  done_q, done_d;
  logic [DW-1:0]         last_sample_q, last_sample_d;

  // FIFO and flags
  logic          overflow_q, underrun_q;
  logic          pop, wr_en, ovf_set, unr_set;
  logic [DW-1:0] fifo_dout;
  logic [AW:0]   fifo_level;
  logic          fifo_full, fifo_empty;

  assign tick    = (tick_cnt_q == TICK_LAST);
  assign pop     = tick && (state_q == ST_IDLE) && !fifo_empty;
  assign unr_set = tick && (state_q == ST_IDLE) && fifo_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign wr_en   = bus.sample_rdy && (!fifo_full || pop);
  assign ovf_set = bus.sample_rdy && !wr_en;

  sample_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk_i     (CLOCK),
    .rst_ni    (RESET),
    .wr_en_i   (wr_en),
    .wr_data_i (bus.sample_in),
    .rd_en_i   (pop),
    .rd_data_o (fifo_dout),
    .level_o   (fifo_level),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  always_comb begin
    state_d       = state_q;
    sr_d          = sr_q;
    bit_cnt_d     = bit_cnt_q;
    half_d        = half_q;
    cs_n_d        = cs_n_q;
    sclk_d        = sclk_q;
    mosi_d        = mosi_q;
    last_sample_d = last_sample_q;
    frame         = '0;

    unique case (state_q)
      ST_IDLE: begin
        cs_n_d = 1'b1;
        sclk_d = 1'b0;
        if (tick) begin
          // On an empty FIFO the previous sample is resent to hold the DAC level.
          if (!fifo_empty) begin
            last_sample_d = fifo_dout;
          end
          frame     = {DAC_CMD, last_sample_d};
          sr_d      = frame;
          mosi_d    = frame[FRAME_BITS-1];
          cs_n_d    = 1'b0;
          bit_cnt_d = '0;
          half_d    = '0;
          state_d   = ST_LOAD;
        end
      end

      ST_LOAD: begin
        half_d  = '0;
        state_d = ST_SHIFT;
      end

      ST_SHIFT: begin
        if (half_q == HALF_LAST) begin
          half_d = '0;
          sclk_d = !sclk_q;
          if (sclk_q) begin
            // Falling edge: present the next bit, or end the frame after the last.
            sr_d = sr_q << 1;
            if (bit_cnt_q == BIT_LAST) begin
              state_d = ST_CS_HOLD;
              cs_n_d  = 1'b1;
              sclk_d  = 1'b0;
              mosi_d  = 1'b0;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
              mosi_d    = sr_q[FRAME_BITS-2];
            end
          end
        end else begin
          half_d = half_q + 1'b1;
        end
      end

      ST_CS_HOLD: begin
        if (half_q == HALF_LAST) begin
          half_d  = '0;
          state_d = ST_IDLE;
        end else begin
          half_d = half_q + 1'b1;
        end
      end
    endcase

    // Registered pulse lands on the final CS_HOLD cycle.
    done_d = (state_d == ST_CS_HOLD) && (half_d == HALF_LAST);
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      tick_cnt_q    <= '0;
      state_q       <= ST_IDLE;
      sr_q          <= '0;
      bit_cnt_q     <= '0;
      half_q        <= '0;
      cs_n_q        <= 1'b1;
      sclk_q        <= 1'b0;
      mosi_q        <= 1'b0;
      done_q        <= 1'b0;
      last_sample_q <= '0;
      overflow_q    <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      tick_cnt_q    <= tick ? '0 : tick_cnt_q + 1'b1;
      state_q       <= state_d;
      sr_q          <= sr_d;
      bit_cnt_q     <= bit_cnt_d;
      half_q        <= half_d;
      cs_n_q        <= cs_n_d;
      sclk_q        <= sclk_d;
      mosi_q        <= mosi_d;
      done_q        <= done_d;
      last_sample_q <= last_sample_d;
      // A set event in the same cycle as clr_flags keeps the flag set.
      overflow_q    <= ovf_set | (overflow_q & ~bus.clr_flags);
      underrun_q    <= unr_set | (underrun_q & ~bus.clr_flags);
    end
  end

  assign bus.dac_cs_n   = cs_n_q;
  assign bus.dac_sclk   = sclk_q;
  assign bus.dac_mosi   = mosi_q;
  assign bus.frame_done = done_q;
  assign bus.fifo_level = fifo_level;
  assign bus.buf_afull  = (fifo_level >= AFULL_LVL);
  assign bus.overflow   = overflow_q;
  assign bus.underrun   = underrun_q;

  // SAMPLE_DIV too small for a whole frame shows up as a tick outside IDLE.
  a_tick_idle: assert property (@(posedge CLOCK) disable iff (!RESET)
    (SAMPLE_DIV >= FRAME_CYCLES + 2) && (!tick || state_q == ST_IDLE));

endmodule
